// File: rtl/fx2_stream_arbiter.sv
// fx2_stream_arbiter: shares the FX2 slave-FIFO IN endpoint between two FWFT sources, one whole packet per grant, round-robin.
// Latency: 0 cycles source-to-pad; SLWR_n, SRCx_READ and USB_STREAM_DATA all act on the head word in the same cycle.
// Backpressure: FLAGS_N[1]=0 (endpoint full) stalls writes and PKTEND; sources are simply not popped. Optional macro: STREAM_HEADER_EN.
module fx2_stream_arbiter #(
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [1:0]  EP_ADDR   = 2'b10
) (
  input  logic        STREAM_CLK,
  input  logic        STREAM_RST,
  input  logic        ENABLE,
  input  logic [15:0] SRC0_DATA,
  input  logic        SRC0_EMPTY,
  output logic        SRC0_READ,
  input  logic [15:0] SRC1_DATA,
  input  logic        SRC1_EMPTY,
  output logic        SRC1_READ,
  input  logic [2:0]  USB_STREAM_FLAGS_N,
  input  logic        USB_STREAM_FX2Rdy,
  output logic [15:0] USB_STREAM_DATA,
  output logic        USB_STREAM_SLWR_n,
  output logic        USB_STREAM_PKTEND_N,
  output logic [1:0]  USB_STREAM_FIFOADDR,
  output logic        BUSY,
  output logic [15:0] PKT_CNT
);

  localparam int unsigned WCW = $clog2(PKT_WORDS);
  localparam int unsigned ICW = $clog2(TIMEOUT);
  localparam logic [WCW-1:0] WC_LAST = WCW'(PKT_WORDS - 1);
  localparam logic [ICW-1:0] IC_LAST = ICW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_src_q, last_src_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
  logic [15:0]    pkt_cnt_q, pkt_cnt_d;

  logic        space_ok;
  logic        grant_empty;
  logic [15:0] grant_data;
  logic        hdr_slot;
  logic        wr;
  logic        src_pop;
  logic        unused_flags;

  // Only the full flag matters; the other FX2 flags are not used here.
  assign unused_flags = ^{USB_STREAM_FLAGS_N[2], USB_STREAM_FLAGS_N[0]};

  assign space_ok    = USB_STREAM_FLAGS_N[1];
  assign grant_empty = grant_q ? SRC1_EMPTY : SRC0_EMPTY;
  assign grant_data  = grant_q ? SRC1_DATA : SRC0_DATA;

`ifdef STREAM_HEADER_EN
  // First slot of every packet carries the header; seq tracks committed packets,
  // which is exactly the low 7 bits of the packet counter.
  assign hdr_slot        = (word_cnt_q == '0);
  assign USB_STREAM_DATA = hdr_slot ? {8'hA5, grant_q, pkt_cnt_q[6:0]} : grant_data;
`else
  assign hdr_slot        = 1'b0;
  assign USB_STREAM_DATA = grant_data;
`endif

  // A header slot writes without needing source data and never pops a source.
  assign wr      = (state_q == ST_WRITE) && space_ok && (hdr_slot || !grant_empty);
  assign src_pop = wr && !hdr_slot;

  assign USB_STREAM_SLWR_n   = ~wr;
  assign USB_STREAM_PKTEND_N = ~((state_q == ST_COMMIT) && space_ok);
  assign SRC0_READ           = src_pop && !grant_q;
  assign SRC1_READ           = src_pop && grant_q;
  assign USB_STREAM_FIFOADDR = EP_ADDR;
  assign BUSY                = (state_q != ST_IDLE);
  assign PKT_CNT             = pkt_cnt_q;

  // Next-state: grant at packet boundaries, count words, close packets on size, timeout or disable.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_src_d = last_src_q;
    word_cnt_d = word_cnt_q;
    idle_cnt_d = idle_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE && USB_STREAM_FX2Rdy && (!SRC0_EMPTY || !SRC1_EMPTY)) begin
          state_d    = ST_WRITE;
          // Both ready: alternate. One ready: SRC0_EMPTY=1 implies source 1 is the ready one.
          grant_d    = (!SRC0_EMPTY && !SRC1_EMPTY) ? ~last_src_q : SRC0_EMPTY;
          word_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      ST_WRITE: begin
        if (wr) begin
          idle_cnt_d = '0;
          if (word_cnt_q == WC_LAST) begin
            // Full packet: FX2 commits it by itself, no PKTEND.
            state_d    = ST_IDLE;
            last_src_d = grant_q;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end else begin
          if (idle_cnt_q != IC_LAST) begin
            idle_cnt_d = idle_cnt_q + ICW'(1);
          end
          if ((idle_cnt_q == IC_LAST) || !ENABLE) begin
            if (word_cnt_q != '0) begin
              state_d = ST_COMMIT;
            end else begin
              // Nothing written: release the grant without a zero-length packet.
              state_d    = ST_IDLE;
              last_src_d = grant_q;
            end
          end
        end
      end
      ST_COMMIT: begin
        if (space_ok) begin
          state_d    = ST_IDLE;
          last_src_d = grant_q;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any open packet without committing it.
  always_ff @(posedge STREAM_CLK or posedge STREAM_RST) begin
    if (STREAM_RST) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      last_src_q <= 1'b1;
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_src_q <= last_src_d;
      word_cnt_q <= word_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_fx2_stream_arbiter.sv
// tb_fx2_stream_arbiter: directed bench for fx2_stream_arbiter with PKT_WORDS=4, TIMEOUT=8.
// Latency: sources are queues; a popped word disappears at the next clock edge.
// Backpressure: the endpoint full flag is driven directly from the stimulus.
module tb_fx2_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] src0_data = 16'h0;
  logic        src0_empty = 1'b1;
  logic        src0_read;
  logic [15:0] src1_data = 16'h0;
  logic        src1_empty = 1'b1;
  logic        src1_read;
  logic [2:0]  flags_n = 3'b111;
  logic        rdy = 1'b1;
  logic [15:0] usb_data;
  logic        slwr_n;
  logic        pktend_n;
  logic [1:0]  fifoaddr;
  logic        busy;
  logic [15:0] pkt_cnt;

  fx2_stream_arbiter #(.PKT_WORDS(4), .TIMEOUT(8), .EP_ADDR(2'b10)) dut (
    .STREAM_CLK          (clk),
    .STREAM_RST          (rst),
    .ENABLE              (enable),
    .SRC0_DATA           (src0_data),
    .SRC0_EMPTY          (src0_empty),
    .SRC0_READ           (src0_read),
    .SRC1_DATA           (src1_data),
    .SRC1_EMPTY          (src1_empty),
    .SRC1_READ           (src1_read),
    .USB_STREAM_FLAGS_N  (flags_n),
    .USB_STREAM_FX2Rdy   (rdy),
    .USB_STREAM_DATA     (usb_data),
    .USB_STREAM_SLWR_n   (slwr_n),
    .USB_STREAM_PKTEND_N (pktend_n),
    .USB_STREAM_FIFOADDR (fifoaddr),
    .BUSY                (busy),
    .PKT_CNT             (pkt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] wr_log[$];
  int          wr_cyc[$];
  int          pk_cyc[$];
  logic        pop0 = 1'b0;
  logic        pop1 = 1'b0;
  logic        en_set = 1'b0;
  logic [2:0]  flags_set = 3'b111;

  typedef struct {
    int              n0;
    int              n1;
    int              cycles;
    int              npk;
    int              pkc;
    logic [3:0][15:0] b;
    logic [3:0][7:0]  c;
  } vec_t;

  function automatic vec_t mk(int n0, int n1, int cycles, int npk, int pkc,
                              logic [15:0] b0, int c0, logic [15:0] b1, int c1,
                              logic [15:0] b2, int c2, logic [15:0] b3, int c3);
    vec_t v;
    v.n0 = n0; v.n1 = n1; v.cycles = cycles; v.npk = npk; v.pkc = pkc;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.c[0] = 8'(c0); v.c[1] = 8'(c1); v.c[2] = 8'(c2); v.c[3] = 8'(c3);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_inputs();
    src0_empty = (q0.size() == 0);
    src0_data  = (q0.size() > 0) ? q0[0] : 16'h0;
    src1_empty = (q1.size() == 0);
    src1_data  = (q1.size() > 0) ? q1[0] : 16'h0;
    enable     = en_set;
    flags_n    = flags_set;
  endtask

  // One clock: update inputs just after the edge, sample outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pop0 && q0.size() > 0) void'(q0.pop_front());
    if (pop1 && q1.size() > 0) void'(q1.pop_front());
    apply_inputs();
    @(negedge clk);
    pop0 = src0_read;
    pop1 = src1_read;
    if (!slwr_n) begin
      wr_log.push_back(usb_data);
      wr_cyc.push_back(cyc);
    end
    if (!pktend_n) pk_cyc.push_back(cyc);
    chk($sformatf("c%0d_slwr_pktend_overlap", cyc), {31'd0, (!slwr_n && !pktend_n)}, 32'd0);
    chk($sformatf("c%0d_dual_read", cyc), {31'd0, (src0_read && src1_read)}, 32'd0);
    chk($sformatf("c%0d_read_empty", cyc),
        {31'd0, ((src0_read && q0.size() == 0) || (src1_read && q1.size() == 0))}, 32'd0);
    if (!flags_n[1])
      chk($sformatf("c%0d_stall_quiet", cyc), {31'd0, (!slwr_n || src0_read || src1_read || !pktend_n)}, 32'd0);
`ifndef STREAM_HEADER_EN
    chk($sformatf("c%0d_read_eq_write", cyc), {31'd0, (src0_read || src1_read)}, {31'd0, !slwr_n});
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    q0.delete(); q1.delete();
    wr_log.delete(); wr_cyc.delete(); pk_cyc.delete();
    pop0 = 1'b0; pop1 = 1'b0;
    en_set = 1'b0; flags_set = 3'b111;
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_writes(input int n, input int bound, input string nm);
    int k = 0;
    while (wr_log.size() < n && k < bound) begin
      step();
      k++;
    end
    chk({nm, "_reached"}, {31'd0, (wr_log.size() >= n)}, 32'd1);
  endtask

  task automatic check_words(input string nm, input logic [15:0] exp_q[$]);
    logic [31:0] act;
    chk({nm, "_nwr"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++) begin
      act = (j < wr_log.size()) ? {16'h0, wr_log[j]} : 32'hDEADBEEF;
      chk($sformatf("%s_word%0d", nm, j), act, {16'h0, exp_q[j]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[5];
    logic [15:0] exp_q[$];
    int          tw;
    int          nstall;

    tbl[0] = mk(4, 0, 30, 0, 1, 16'h1000, 4, 16'h0, 0, 16'h0, 0, 16'h0, 0);
    tbl[1] = mk(8, 8, 40, 0, 4, 16'h1000, 4, 16'h2000, 4, 16'h1004, 4, 16'h2004, 4);
    tbl[2] = mk(3, 0, 30, 1, 1, 16'h1000, 3, 16'h0, 0, 16'h0, 0, 16'h0, 0);
    tbl[3] = mk(0, 5, 40, 1, 2, 16'h2000, 5, 16'h0, 0, 16'h0, 0, 16'h0, 0);
    tbl[4] = mk(2, 1, 50, 2, 2, 16'h1000, 2, 16'h2000, 1, 16'h0, 0, 16'h0, 0);

    // Reset state
    do_reset();
    chk("rst_slwr_n", {31'd0, slwr_n}, 32'd1);
    chk("rst_pktend_n", {31'd0, pktend_n}, 32'd1);
    chk("rst_reads", {30'd0, src1_read, src0_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    chk("fifoaddr", {30'd0, fifoaddr}, 32'd2);

`ifdef STREAM_HEADER_EN
    // Header build: source 1 only, packets open with 0xA58n.
    do_reset();
    for (int k = 0; k < 7; k++) q1.push_back(16'h2000 + 16'(k));
    en_set = 1'b1;
    repeat (60) step();
    exp_q = '{16'hA580, 16'h2000, 16'h2001, 16'h2002,
              16'hA581, 16'h2003, 16'h2004, 16'h2005,
              16'hA582, 16'h2006};
    check_words("hdr", exp_q);
    chk("hdr_pktend", 32'(pk_cyc.size()), 32'd1);
    chk("hdr_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
    chk("hdr_src1_drained", 32'(q1.size()), 32'd0);
    chk("hdr_busy", {31'd0, busy}, 32'd0);
`else
    // Table-driven packet scenarios
    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int k = 0; k < tbl[i].n0; k++) q0.push_back(16'h1000 + 16'(k));
      for (int k = 0; k < tbl[i].n1; k++) q1.push_back(16'h2000 + 16'(k));
      en_set = 1'b1;
      repeat (tbl[i].cycles) step();
      exp_q.delete();
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < int'(tbl[i].c[r]); j++) exp_q.push_back(tbl[i].b[r] + 16'(j));
      check_words($sformatf("vec%0d", i), exp_q);
      chk($sformatf("vec%0d_pktend", i), 32'(pk_cyc.size()), 32'(tbl[i].npk));
      chk($sformatf("vec%0d_pkt_cnt", i), {16'd0, pkt_cnt}, 32'(tbl[i].pkc));
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Short packet: PKTEND after 8 idle cycles, i.e. 9 cycles after the last write.
    do_reset();
    for (int k = 0; k < 3; k++) q0.push_back(16'h1000 + 16'(k));
    en_set = 1'b1;
    run_until_writes(3, 20, "short");
    begin
      int k = 0;
      while (pk_cyc.size() == 0 && k < 30) begin step(); k++; end
    end
    step();
    chk("short_pktend_count", 32'(pk_cyc.size()), 32'd1);
    tw = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : 0;
    chk("short_pktend_delay", 32'((pk_cyc.size() > 0) ? pk_cyc[0] - tw : -1), 32'd9);
    chk("short_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    // Commit held while endpoint full, then one PKTEND once space returns.
    do_reset();
    for (int k = 0; k < 3; k++) q0.push_back(16'h1000 + 16'(k));
    en_set = 1'b1;
    run_until_writes(3, 20, "cfull");
    flags_set = 3'b101;
    repeat (15) step();
    chk("cfull_no_pktend", 32'(pk_cyc.size()), 32'd0);
    chk("cfull_busy", {31'd0, busy}, 32'd1);
    chk("cfull_pkt_cnt_hold", {16'd0, pkt_cnt}, 32'd0);
    flags_set = 3'b111;
    repeat (5) step();
    chk("cfull_pktend", 32'(pk_cyc.size()), 32'd1);
    chk("cfull_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    // Backpressure mid-packet: no writes for 5 stalled cycles, no loss or duplicate.
    do_reset();
    for (int k = 0; k < 4; k++) q0.push_back(16'h1000 + 16'(k));
    en_set = 1'b1;
    run_until_writes(2, 20, "bp");
    flags_set = 3'b101;
    repeat (5) step();
    nstall = wr_log.size();
    chk("bp_stall_writes", 32'(nstall), 32'd2);
    flags_set = 3'b111;
    repeat (10) step();
    exp_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    check_words("bp", exp_q);
    chk("bp_pktend", 32'(pk_cyc.size()), 32'd0);
    chk("bp_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

    // Disable after 2 words: PKTEND on the next idle cycle, then no new grant.
    do_reset();
    for (int k = 0; k < 2; k++) q0.push_back(16'h1000 + 16'(k));
    en_set = 1'b1;
    run_until_writes(2, 20, "dis");
    en_set = 1'b0;
    repeat (5) step();
    chk("dis_pktend", 32'(pk_cyc.size()), 32'd1);
    tw = (wr_cyc.size() > 1) ? wr_cyc[1] : 0;
    chk("dis_pktend_delay", 32'((pk_cyc.size() > 0) ? pk_cyc[0] - tw : -1), 32'd2);
    chk("dis_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    for (int k = 0; k < 3; k++) q0.push_back(16'h3000 + 16'(k));
    repeat (10) step();
    chk("dis_no_grant_writes", 32'(wr_log.size()), 32'd2);
    chk("dis_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of the second packet.
    do_reset();
    for (int k = 0; k < 6; k++) q0.push_back(16'h1000 + 16'(k));
    en_set = 1'b1;
    run_until_writes(6, 30, "arst");
    chk("arst_pre_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    chk("arst_pre_slwr_n", {31'd0, slwr_n}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_slwr_n", {31'd0, slwr_n}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    chk("arst_read", {31'd0, src0_read}, 32'd0);
    chk("arst_pktend_n", {31'd0, pktend_n}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
